// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and queue entry type for the instruction fetch unit
package fetch_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 9;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch unit bus: instruction memory port plus decode-side queue head
interface fetch_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9,
  parameter int DEPTH  = 4
) ();
  logic                       imem_req;
  logic [PC_W-1:0]            imem_addr;
  logic [DATA_W-1:0]          imem_rdata;
  logic                       stall;
  logic                       redirect;
  logic [PC_W-1:0]            redirect_pc;
  logic                       instr_valid;
  logic [DATA_W-1:0]          instr;
  logic [PC_W-1:0]            instr_pc;
  logic [$clog2(DEPTH+1)-1:0] queue_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, queue_count,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, queue_count,
    output imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue: synchronous FIFO with flush and occupancy count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  output entry_t                     rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= r_wr + AW'(1);
      if (pop)  r_rd <= r_rd + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr] <= wdata;
  end

  always @(posedge clk) begin
    if (!reset) assert (!(push && !flush && r_count == CW'(DEPTH)));
  end

  // Empty queue presents all-zero head rather than stale storage
  assign rdata = (r_count != '0) ? r_mem[r_rd] : '0;
  assign count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC sequencing, request throttling, redirect flush
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_inflight_pc;
  logic            r_inflight;

  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  entry_t          w_wdata;
  entry_t          w_head;

  // Slots already promised to an outstanding response count as occupied
  assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_req   = !reset && !bus.redirect && (w_occ < DEPTH_C);
  assign w_valid = (w_count != '0);
  assign w_push  = r_inflight && !bus.redirect;
  assign w_pop   = w_valid && !bus.stall && !bus.redirect;
  assign w_wdata = '{pc: r_inflight_pc, instr: bus.imem_rdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.redirect) begin
      r_pc       <= bus.redirect_pc & ~PC_W'(3);
      r_inflight <= 1'b0;
    end else begin
      r_inflight    <= w_req;
      r_inflight_pc <= r_pc;
      if (w_req) r_pc <= r_pc + PC_W'(4);
    end
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_head),
    .count (w_count)
  );

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_head.instr;
  assign bus.instr_pc    = w_head.pc;
  assign bus.queue_count = w_count;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a queue model
module tb_fetch_unit;
  localparam int DATA_W = 32;
  localparam int PC_W   = 9;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  fetch_unit #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [PC_W-1:0] q_pc [$];
  logic            m_inf;
  logic [PC_W-1:0] m_inf_pc;
  logic [PC_W-1:0] m_pc;
  logic            rsp_valid;
  logic [PC_W-1:0] rsp_addr;

  function automatic logic [DATA_W-1:0] rom(input logic [PC_W-1:0] a);
    return (32'h9E37_79B9 * {23'b0, a}) ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},   64'(bus.imem_req),    64'd0);
    check({tag, "_addr"},  64'(bus.imem_addr),   64'd0);
    check({tag, "_valid"}, 64'(bus.instr_valid), 64'd0);
    check({tag, "_instr"}, 64'(bus.instr),       64'd0);
    check({tag, "_ipc"},   64'(bus.instr_pc),    64'd0);
    check({tag, "_count"}, 64'(bus.queue_count), 64'd0);
  endtask

  task automatic model_clear();
    q_pc.delete();
    m_inf     = 1'b0;
    m_inf_pc  = '0;
    m_pc      = '0;
    rsp_valid = 1'b0;
    rsp_addr  = '0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model
  task automatic step(input logic s, input logic r, input logic [PC_W-1:0] rp);
    logic exp_req;
    @(negedge clk);
    bus.imem_rdata  = rsp_valid ? rom(rsp_addr) : DATA_W'($urandom);
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rp;
    #1;
    exp_req = !r && (q_pc.size() + int'(m_inf)) < DEPTH;
    check("req",   64'(bus.imem_req),    64'(exp_req));
    check("addr",  64'(bus.imem_addr),   64'(m_pc));
    check("valid", 64'(bus.instr_valid), 64'(q_pc.size() != 0));
    check("ipc",   64'(bus.instr_pc),    q_pc.size() != 0 ? 64'(q_pc[0]) : 64'd0);
    check("instr", 64'(bus.instr),       q_pc.size() != 0 ? 64'(rom(q_pc[0])) : 64'd0);
    check("count", 64'(bus.queue_count), 64'(q_pc.size()));
    rsp_valid = bus.imem_req;
    rsp_addr  = bus.imem_addr;
    if (r) begin
      q_pc.delete();
      m_inf = 1'b0;
      m_pc  = {rp[PC_W-1:2], 2'b00};
    end else begin
      if (q_pc.size() != 0 && !s) void'(q_pc.pop_front());
      if (m_inf) q_pc.push_back(m_inf_pc);
      m_inf    = exp_req;
      m_inf_pc = m_pc;
      if (exp_req) m_pc = m_pc + PC_W'(4);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_idle("rst_async");
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_idle("rst_hold");
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run(input int n, input logic s);
    for (int i = 0; i < n; i++) step(s, 1'b0, '0);
  endtask

  initial begin
    bus.imem_rdata  = '0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    model_clear();
    #1 check_idle("rst_init");
    do_reset(3);

    run(12, 1'b0);

    do_reset(2);
    run(10, 1'b1);
    check("stall_full", 64'(bus.queue_count), 64'(DEPTH));
    run(10, 1'b0);

    for (int i = 0; i < 12 && q_pc.size() != DEPTH; i++) step(1'b1, 1'b0, '0);
    check("pre_redirect_full", 64'(q_pc.size()), 64'(DEPTH));
    step(1'b1, 1'b1, 9'h0A3);
    run(6, 1'b0);

    step(1'b0, 1'b1, 9'h040);
    step(1'b0, 1'b1, 9'h080);
    run(8, 1'b0);

    step(1'b0, 1'b1, 9'h1F8);
    run(8, 1'b0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, PC_W'($urandom));

    do_reset(1);
    for (int i = 0; i < 12 && !(q_pc.size() == 3 && m_inf); i++) step(1'b1, 1'b0, '0);
    check("prefill3", 64'(q_pc.size() == 3 && m_inf), 64'd1);
    do_reset(2);
    run(6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
